// File: rtl/sram_controller_pkg.sv
//==============================================================================
// Module   : sram_controller_pkg
// Desc     : Shared constants for the 32-bit to 16-bit async SRAM bridge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package sram_controller_pkg;

    localparam int unsigned c_sram_data_w = 16;
    localparam int unsigned c_sram_addr_w = 18;

    localparam logic [31:0] c_default_base_addr = 32'h0000_0400;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_low  = 3'd1;
    localparam logic [2:0] c_st_high = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sram_controller.sv
//==============================================================================
// Module   : sram_controller
// Desc     : Splits 32-bit MEM-stage reads/writes into two 16-bit async SRAM
//            accesses (low half, then high half) and stalls the pipeline.
// Optional : define SRAM_ACCESS_COUNT_EN to add the accessCount output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = c_default_base_addr,
    parameter int unsigned ACCESS_CYCLES = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              address,
    input  logic [31:0]              dataIn,
    inout  wire  [c_sram_data_w-1:0] SRAMData,
    output logic [c_sram_addr_w-1:0] SRAMAddress,
    output logic                     SRAMUB,
    output logic                     SRAMLB,
    output logic                     SRAMOE,
    output logic                     SRAMCE,
    output logic                     SRAMWE,
    output logic [31:0]              dataOut,
`ifdef SRAM_ACCESS_COUNT_EN
    output logic [31:0]              accessCount,
`endif
    output logic                     freeze
);

    localparam int unsigned            c_cnt_w     = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0]     c_wait_load = c_cnt_w'(ACCESS_CYCLES - 4);
    localparam logic [c_cnt_w-1:0]     c_cnt_one   = c_cnt_w'(1);

    logic [2:0]               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [31:0]              r_addr;
    logic [31:0]              r_data;
    logic                     r_op_wr;
    logic [31:0]              r_dout;

    logic [c_sram_addr_w-2:0] w_word;
    logic                     w_in_xfer;
    logic                     w_drive;
    logic [c_sram_data_w-1:0] w_wr_half;

    // Upper offset bits beyond the SRAM span fall off in the truncation.
    assign w_word    = (c_sram_addr_w - 1)'((r_addr - BASE_ADDR) >> 2);
    assign w_in_xfer = (r_state == c_st_low) || (r_state == c_st_high);
    assign w_drive   = r_op_wr && w_in_xfer;
    assign w_wr_half = (r_state == c_st_low) ? r_data[15:0] : r_data[31:16];

    assign SRAMData  = w_drive ? w_wr_half : {c_sram_data_w{1'bz}};
    assign SRAMWE    = ~w_drive;
    assign SRAMUB    = 1'b0;
    assign SRAMLB    = 1'b0;
    assign SRAMOE    = 1'b0;
    assign SRAMCE    = 1'b0;
    assign dataOut   = r_dout;

    assign freeze = ((r_state == c_st_idle) && (read || write)) ||
                    w_in_xfer || (r_state == c_st_wait);

    // High half is held through WAIT/DONE so the address outlasts the WE edge.
    always_comb begin
        SRAMAddress = '0;
        case (r_state)
            c_st_idle: SRAMAddress = '0;
            c_st_low:  SRAMAddress = {w_word, 1'b0};
            default:   SRAMAddress = {w_word, 1'b1};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_op_wr <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (write || read) begin
                        r_addr  <= address;
                        r_data  <= dataIn;
                        r_op_wr <= write;
                        r_state <= c_st_low;
                    end
                end
                c_st_low: begin
                    if (!r_op_wr) begin
                        r_dout[15:0] <= SRAMData;
                    end
                    r_state <= c_st_high;
                end
                c_st_high: begin
                    if (!r_op_wr) begin
                        r_dout[31:16] <= SRAMData;
                    end
                    r_cnt   <= c_wait_load;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    logic [31:0] r_access_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_access_cnt <= '0;
        end else if ((r_state == c_st_wait) && (r_cnt == c_cnt_one)) begin
            r_access_cnt <= r_access_cnt + 32'd1;
        end
    end

    assign accessCount = r_access_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
//==============================================================================
// Module   : tb_sram_controller
// Desc     : Self-checking bench for sram_controller with an SRAM model and
//            write/read scoreboards.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_controller;

    localparam logic [15:0] c_probe = 16'hBEEF;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] dataIn = '0;
    wire  [15:0] SRAMData;
    logic [17:0] SRAMAddress;
    logic        SRAMUB, SRAMLB, SRAMOE, SRAMCE, SRAMWE;
    logic [31:0] dataOut;
    logic        freeze;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [31:0] accessCount;
`endif

    int   checks = 0;
    int   errors = 0;
    logic model_en = 1'b0;
    logic [15:0] mem [0:262143];
    wr_t  wq[$];
    logic [31:0] rq[$];

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .read        (read),
        .write       (write),
        .address     (address),
        .dataIn      (dataIn),
        .SRAMData    (SRAMData),
        .SRAMAddress (SRAMAddress),
        .SRAMUB      (SRAMUB),
        .SRAMLB      (SRAMLB),
        .SRAMOE      (SRAMOE),
        .SRAMCE      (SRAMCE),
        .SRAMWE      (SRAMWE),
        .dataOut     (dataOut),
`ifdef SRAM_ACCESS_COUNT_EN
        .accessCount (accessCount),
`endif
        .freeze      (freeze)
    );

    always #5 clk = ~clk;

    // SRAM side: drives stored data (or a probe value) whenever WE is high.
    assign SRAMData = (SRAMWE === 1'b1) ? (model_en ? mem[SRAMAddress] : c_probe) : 16'hzzzz;

    always @(negedge clk) begin
        wr_t e;
        if (rst && SRAMWE === 1'b0) begin
            mem[SRAMAddress] = SRAMData;
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL sram_write unexpected addr=%h data=%h", SRAMAddress, SRAMData);
            end else begin
                e = wq.pop_front();
                if (SRAMAddress !== e.a || SRAMData !== e.d) begin
                    errors++;
                    $display("FAIL sram_write got addr=%h data=%h expected addr=%h data=%h",
                             SRAMAddress, SRAMData, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and returns at the negedge of its freeze-low cycle.
    task automatic run_op(input logic wr, input logic rd, input int hold,
                          output int fz, output int wep, output logic [15:0] bus_done,
                          output logic [15:0] dlow);
        fz = 0;
        wep = 0;
        bus_done = '0;
        dlow = '0;
        write = wr;
        read = rd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) dlow = dataOut[15:0];
            if (freeze === 1'b0) begin
                bus_done = SRAMData;
                return;
            end
            fz++;
            if (SRAMWE === 1'b0) wep++;
            @(posedge clk);
            #1;
            if (hold > 0 && i + 1 == hold) begin
                write = 1'b0;
                read = 1'b0;
            end
        end
        checks++;
        errors++;
        $display("FAIL op_timeout freeze still high after 20 cycles");
        write = 1'b0;
        read = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (SRAMWE !== 1'b1) begin errors++; $display("FAIL rst_we got %b expected 1", SRAMWE); end
        checks++;
        if (SRAMData !== c_probe) begin errors++; $display("FAIL rst_bus got %h expected released (%h)", SRAMData, c_probe); end
        checks++;
        if (dataOut !== 32'h0) begin errors++; $display("FAIL rst_dout got %h expected 0", dataOut); end
        checks++;
        if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %b expected 0", freeze); end
        checks++;
        if (SRAMAddress !== 18'h0) begin errors++; $display("FAIL rst_addr got %h expected 0", SRAMAddress); end
        checks++;
        if ({SRAMUB, SRAMLB, SRAMOE, SRAMCE} !== 4'b0000) begin
            errors++; $display("FAIL const_en got %b expected 0000", {SRAMUB, SRAMLB, SRAMOE, SRAMCE});
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int fz, wep;
        logic [15:0] bus, dl;
        model_en = 1'b0;
        address = 32'h1000;
        dataIn = 32'h1234_5678;
        wq.push_back('{a: 18'h600, d: 16'h5678});
        wq.push_back('{a: 18'h601, d: 16'h1234});
        run_op(1'b1, 1'b0, 2, fz, wep, bus, dl);
        checks++;
        if (fz != 5) begin errors++; $display("FAIL wr_freeze_len got %0d expected 5", fz); end
        checks++;
        if (wep != 2) begin errors++; $display("FAIL wr_we_pulses got %0d expected 2", wep); end
        checks++;
        if (bus !== c_probe) begin errors++; $display("FAIL wr_bus_release got %h expected %h", bus, c_probe); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL wr_pending got %0d expected 0", wq.size()); end
        tick();
    endtask

    task automatic test_read();
        int fz, wep;
        logic [15:0] bus, dl;
        logic [31:0] exp;
        model_en = 1'b1;
        mem[18'h600] = 16'h6785;
        mem[18'h601] = 16'h3452;
        address = 32'h1000;
        rq.push_back(32'h3452_6785);
        run_op(1'b0, 1'b1, 2, fz, wep, bus, dl);
        exp = rq.pop_front();
        checks++;
        if (dl !== 16'h6785) begin errors++; $display("FAIL rd_low got %h expected 6785", dl); end
        checks++;
        if (dataOut !== exp) begin errors++; $display("FAIL rd_data got %h expected %h", dataOut, exp); end
        checks++;
        if (fz != 5) begin errors++; $display("FAIL rd_freeze_len got %0d expected 5", fz); end
        checks++;
        if (wep != 0) begin errors++; $display("FAIL rd_we_pulses got %0d expected 0", wep); end
        tick();
    endtask

    task automatic test_both();
        int fz, wep;
        logic [15:0] bus, dl;
        logic [31:0] exp;
        model_en = 1'b1;
        address = 32'h2000;
        dataIn = 32'hCAFE_BABE;
        wq.push_back('{a: 18'hE00, d: 16'hBABE});
        wq.push_back('{a: 18'hE01, d: 16'hCAFE});
        run_op(1'b1, 1'b1, 2, fz, wep, bus, dl);
        checks++;
        if (wep != 2) begin errors++; $display("FAIL both_we_pulses got %0d expected 2", wep); end
        checks++;
        if (dataOut !== 32'h3452_6785) begin errors++; $display("FAIL both_dout got %h expected 34526785", dataOut); end
        tick();
        dataIn = 32'h0;
        rq.push_back(32'hCAFE_BABE);
        run_op(1'b0, 1'b1, 1, fz, wep, bus, dl);
        exp = rq.pop_front();
        checks++;
        if (dataOut !== exp) begin errors++; $display("FAIL readback got %h expected %h", dataOut, exp); end
        tick();
    endtask

    task automatic test_async_reset();
        model_en = 1'b0;
        address = 32'h1000;
        dataIn = 32'hFFFF_0000;
        write = 1'b1;
        tick();
        write = 1'b0;
        checks++;
        if (SRAMWE !== 1'b0) begin errors++; $display("FAIL arst_pre_we got %b expected 0", SRAMWE); end
        rst = 1'b0;
        #1;
        checks++;
        if (SRAMWE !== 1'b1) begin errors++; $display("FAIL arst_we got %b expected 1", SRAMWE); end
        checks++;
        if (SRAMData !== c_probe) begin errors++; $display("FAIL arst_bus got %h expected %h", SRAMData, c_probe); end
        checks++;
        if (dataOut !== 32'h0) begin errors++; $display("FAIL arst_dout got %h expected 0", dataOut); end
        checks++;
        if (freeze !== 1'b0 || SRAMAddress !== 18'h0) begin
            errors++; $display("FAIL arst_idle got freeze=%b addr=%h expected 0/0", freeze, SRAMAddress);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_addr_map();
        int fz, wep;
        logic [15:0] bus, dl;
        logic [31:0] addrs [3] = '{32'h0000_1003, 32'h0008_0400, 32'h0000_03FC};
        logic [17:0] lows  [3] = '{18'h00600, 18'h00000, 18'h3FFFE};
        logic [31:0] datas [3] = '{32'h1111_2222, 32'hA5A5_5A5A, 32'h0F0F_F0F0};
        model_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            address = addrs[k];
            dataIn = datas[k];
            wq.push_back('{a: lows[k], d: datas[k][15:0]});
            wq.push_back('{a: lows[k] | 18'h1, d: datas[k][31:16]});
            run_op(1'b1, 1'b0, 1, fz, wep, bus, dl);
            checks++;
            if (wep != 2) begin errors++; $display("FAIL map_we_pulses[%0d] got %0d expected 2", k, wep); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int fz, wep;
        logic [15:0] bus, dl;
        logic [31:0] exp;
        model_en = 1'b1;
        address = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            rq.push_back(32'h1111_2222);
            run_op(1'b0, 1'b1, 0, fz, wep, bus, dl);
            exp = rq.pop_front();
            checks++;
            if (fz != 5) begin errors++; $display("FAIL b2b_freeze_len[%0d] got %0d expected 5", k, fz); end
            checks++;
            if (dataOut !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h expected %h", k, dataOut, exp); end
            if (k == 2) read = 1'b0;
            tick();
        end
        #3;
        checks++;
        if (freeze !== 1'b0) begin errors++; $display("FAIL b2b_extra_op got freeze=%b expected 0", freeze); end
        tick();
    endtask

`ifdef SRAM_ACCESS_COUNT_EN
    task automatic test_access_count();
        int fz, wep;
        logic [15:0] bus, dl;
        logic [31:0] exp;
        rst = 1'b0;
        #1;
        checks++;
        if (accessCount !== 32'd0) begin errors++; $display("FAIL cnt_reset got %0d expected 0", accessCount); end
        tick();
        rst = 1'b1;
        tick();
        model_en = 1'b1;
        address = 32'h1000;
        for (int k = 0; k < 2; k++) begin
            rq.push_back(32'h1111_2222);
            run_op(1'b0, 1'b1, 1, fz, wep, bus, dl);
            exp = rq.pop_front();
            checks++;
            if (dataOut !== exp) begin errors++; $display("FAIL cnt_rd[%0d] got %h expected %h", k, dataOut, exp); end
            tick();
        end
        checks++;
        if (accessCount !== 32'd2) begin errors++; $display("FAIL cnt_two got %0d expected 2", accessCount); end
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        tick();
        checks++;
        if (freeze !== 1'b1) begin errors++; $display("FAIL cnt_in_wait got freeze=%b expected 1", freeze); end
        rst = 1'b0;
        #1;
        checks++;
        if (accessCount !== 32'd0 || SRAMWE !== 1'b1 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL cnt_arst got cnt=%0d we=%b freeze=%b expected 0/1/0", accessCount, SRAMWE, freeze);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both();
        test_async_reset();
        test_addr_map();
        test_back_to_back();
`ifdef SRAM_ACCESS_COUNT_EN
        test_access_count();
`endif
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got wq=%0d rq=%0d expected 0/0", wq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
